lcd_receiver: RTL and testbench

LCD_RECEIVER -- requirements
Module: lcd_receiver

---
 rtl/lcd_receiver.sv | 140 ++++++++++++++
 tb/tb_lcd_receiver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_receiver.sv
// Two-chip LCD panel bus receiver: captures driver transfers on the en strobe and turns them
// into frame-buffer writes, per-chip display state and status read-back.
module lcd_receiver (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  db_i,
    input  logic        dori_i,
    input  logic [1:0]  cs_i,
    input  logic        en_i,
    input  logic        rw_i,
    input  logic        rst_i,
    output logic        fb_we_o,
    output logic [9:0]  fb_addr_o,
    output logic [7:0]  fb_data_o,
    output logic [1:0]  disp_on_o,
    output logic [11:0] start_line_o,
    output logic        frame_done_o,
    output logic [7:0]  db_o,
    output logic        db_oe_o
);
    logic            en_q;
    logic [7:0]      cap_db;
    logic            cap_dori;
    logic            cap_rw;
    logic [1:0]      cap_cs;
    logic [1:0][5:0] col;
    logic [1:0][2:0] page;
    logic [1:0][5:0] start_line;
    logic            chip1_pending;
    logic [7:0]      chip1_data;

    logic fall;
    logic is_disp;
    logic is_col;
    logic is_page;
    logic is_line;
    logic status_chip;

    assign start_line_o = start_line;

    always_comb begin
        fall        = en_q & ~en_i;
        is_disp     = (cap_db[7:1] == 7'b0011111);
        is_col      = (cap_db[7:6] == 2'b01);
        is_page     = (cap_db[7:3] == 5'b10111);
        is_line     = (cap_db[7:6] == 2'b11);
        status_chip = ~cap_cs[0];
    end

    // The bus is sampled while en is high; execution uses only these copies.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q     <= 1'b0;
            cap_db   <= '0;
            cap_dori <= 1'b0;
            cap_rw   <= 1'b0;
            cap_cs   <= '0;
        end else begin
            en_q <= en_i;
            if (en_i) begin
                cap_db   <= db_i;
                cap_dori <= dori_i;
                cap_rw   <= rw_i;
                cap_cs   <= cs_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col           <= '0;
            page          <= '0;
            start_line    <= '0;
            disp_on_o     <= '0;
            fb_we_o       <= 1'b0;
            fb_addr_o     <= '0;
            fb_data_o     <= '0;
            frame_done_o  <= 1'b0;
            db_o          <= '0;
            db_oe_o       <= 1'b0;
            chip1_pending <= 1'b0;
            chip1_data    <= '0;
        end else begin
            fb_we_o       <= 1'b0;
            frame_done_o  <= 1'b0;
            db_o          <= '0;
            db_oe_o       <= 1'b0;
            chip1_pending <= 1'b0;

            // Second half of a both-chip data write; a panel reset in between cancels it.
            if (chip1_pending && !rst_i) begin
                fb_we_o   <= 1'b1;
                fb_addr_o <= {1'b1, page[1], col[1]};
                fb_data_o <= chip1_data;
                col[1]    <= col[1] + 6'd1;
            end

            if (fall && (cap_cs != 2'b00)) begin
                if (cap_rw) begin
                    db_oe_o <= 1'b1;
                    if (!cap_dori)
                        db_o <= {2'b00, ~disp_on_o[status_chip], rst_i, 4'b0000};
                end else if (!rst_i) begin
                    if (cap_dori) begin
                        fb_we_o   <= 1'b1;
                        fb_data_o <= cap_db;
                        if (cap_cs[0]) begin
                            fb_addr_o     <= {1'b0, page[0], col[0]};
                            col[0]        <= col[0] + 6'd1;
                            chip1_pending <= cap_cs[1];
                            chip1_data    <= cap_db;
                        end else begin
                            fb_addr_o <= {1'b1, page[1], col[1]};
                            col[1]    <= col[1] + 6'd1;
                        end
                    end else begin
                        for (int c = 0; c < 2; c++) begin
                            if (cap_cs[c]) begin
                                if (is_disp) disp_on_o[c]  <= cap_db[0];
                                if (is_col)  col[c]        <= cap_db[5:0];
                                if (is_page) page[c]       <= cap_db[2:0];
                                if (is_line) start_line[c] <= cap_db[5:0];
                            end
                        end
                        if (is_disp && cap_db[0])
                            frame_done_o <= 1'b1;
                    end
                end
            end

            // Panel reset pins all per-chip state at zero for as long as it is held.
            if (rst_i) begin
                disp_on_o  <= '0;
                col        <= '0;
                page       <= '0;
                start_line <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lcd_receiver.sv
// Self-checking bench for lcd_receiver: a transaction-level model predicts every output each
// cycle, and directed scenarios pin the model against hand-computed literals.
module tb_lcd_receiver;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  db_i = '0;
    logic        dori_i = 1'b0;
    logic [1:0]  cs_i = '0;
    logic        en_i = 1'b0;
    logic        rw_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        fb_we_o;
    logic [9:0]  fb_addr_o;
    logic [7:0]  fb_data_o;
    logic [1:0]  disp_on_o;
    logic [11:0] start_line_o;
    logic        frame_done_o;
    logic [7:0]  db_o;
    logic        db_oe_o;

    int vectors = 0;
    int miscompares = 0;

    lcd_receiver dut (
        .clk(clk), .rstn(rstn), .db_i(db_i), .dori_i(dori_i), .cs_i(cs_i), .en_i(en_i),
        .rw_i(rw_i), .rst_i(rst_i), .fb_we_o(fb_we_o), .fb_addr_o(fb_addr_o),
        .fb_data_o(fb_data_o), .disp_on_o(disp_on_o), .start_line_o(start_line_o),
        .frame_done_o(frame_done_o), .db_o(db_o), .db_oe_o(db_oe_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dori;
        logic       rw;
        logic [1:0] cs;
        logic [7:0] db;
        int         exec;
    } xfer_t;

    xfer_t xfer_q[$];
    xfer_t cur;
    int    cyc = 0;

    // Model state: plain integers for column/page/line, and the expected registered outputs.
    int         m_col[2]  = '{0, 0};
    int         m_page[2] = '{0, 0};
    int         m_line[2] = '{0, 0};
    logic [1:0] m_disp = '0;
    logic       m_we = 1'b0, m_fd = 1'b0, m_oe = 1'b0;
    logic [9:0] m_addr = '0;
    logic [7:0] m_data = '0, m_db = '0;
    logic       m_chip1_due = 1'b0;
    logic [7:0] m_chip1_data = '0;

    logic [17:0] wr_log[$];
    int          wr_cyc[$];
    logic [7:0]  rd_log[$];
    int          fd_count = 0;
    logic [42:0] act_vec, exp_vec;

    always @(posedge clk or negedge rstn) begin
        cyc++;
        if (!rstn) begin
            m_col = '{0, 0}; m_page = '{0, 0}; m_line = '{0, 0};
            m_disp = '0; m_we = 0; m_fd = 0; m_oe = 0;
            m_addr = '0; m_data = '0; m_db = '0; m_chip1_due = 0;
            xfer_q.delete();
        end else begin
            m_we = 0; m_fd = 0; m_oe = 0; m_db = '0;
            if (m_chip1_due) begin
                m_chip1_due = 0;
                if (!rst_i) begin
                    m_we = 1;
                    m_addr = 10'(512 + 64 * m_page[1] + m_col[1]);
                    m_data = m_chip1_data;
                    m_col[1] = (m_col[1] + 1) % 64;
                end
            end
            if (xfer_q.size() > 0 && xfer_q[0].exec == cyc) begin
                cur = xfer_q.pop_front();
                if (cur.cs != 2'b00) begin
                    if (cur.rw) begin
                        m_oe = 1;
                        if (!cur.dori)
                            m_db = (m_disp[cur.cs[0] ? 0 : 1] ? 8'h00 : 8'h20) | (rst_i ? 8'h10 : 8'h00);
                    end else if (!rst_i) begin
                        if (cur.dori) begin
                            int first;
                            first = cur.cs[0] ? 0 : 1;
                            m_we = 1;
                            m_addr = 10'(512 * first + 64 * m_page[first] + m_col[first]);
                            m_data = cur.db;
                            m_col[first] = (m_col[first] + 1) % 64;
                            if (cur.cs == 2'b11) begin
                                m_chip1_due = 1;
                                m_chip1_data = cur.db;
                            end
                        end else begin
                            for (int c = 0; c < 2; c++) begin
                                if (cur.cs[c]) begin
                                    if (cur.db == 8'h3E || cur.db == 8'h3F) m_disp[c] = cur.db[0];
                                    else if (cur.db >= 8'h40 && cur.db < 8'h80) m_col[c] = int'(cur.db) - 64;
                                    else if (cur.db >= 8'hB8 && cur.db <= 8'hBF) m_page[c] = int'(cur.db) - 184;
                                    else if (cur.db >= 8'hC0) m_line[c] = int'(cur.db) - 192;
                                end
                            end
                            if (cur.db == 8'h3F) m_fd = 1;
                        end
                    end
                end
            end
            if (rst_i) begin
                m_col = '{0, 0}; m_page = '{0, 0}; m_line = '{0, 0}; m_disp = '0;
            end
        end
    end

    // Every falling edge: compare the whole output set against the model and log events.
    always @(negedge clk) begin
        act_vec = {fb_we_o, fb_addr_o, fb_data_o, disp_on_o, start_line_o, frame_done_o, db_o, db_oe_o};
        exp_vec = {m_we, m_addr, m_data, m_disp, 6'(m_line[1]), 6'(m_line[0]), m_fd, m_db, m_oe};
        vectors++;
        if (act_vec !== exp_vec) begin
            miscompares++;
            $display("[TB] FAIL cycle_outputs at %0t: got 0x%011h, expected 0x%011h", $time, act_vec, exp_vec);
        end
        if (fb_we_o === 1'b1) begin
            wr_log.push_back({fb_addr_o, fb_data_o});
            wr_cyc.push_back(cyc);
        end
        if (frame_done_o === 1'b1) fd_count++;
        if (db_oe_o === 1'b1) rd_log.push_back(db_o);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearLogs();
        wr_log.delete();
        wr_cyc.delete();
        rd_log.delete();
        fd_count = 0;
    endtask

    // One bus transfer; mid_action 1 raises rst_i, 2 pulses rstn, just after the executing edge.
    task automatic applyStimulus(input logic dori, input logic rw, input logic [1:0] cs,
                                 input logic [7:0] db, input int mid_action);
        xfer_t x;
        @(negedge clk); #1;
        db_i = db; dori_i = dori; cs_i = cs; rw_i = rw; en_i = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        en_i = 1'b0;
        x.dori = dori; x.rw = rw; x.cs = cs; x.db = db; x.exec = cyc + 1;
        xfer_q.push_back(x);
        db_i = ~db; dori_i = ~dori; cs_i = ~cs; rw_i = ~rw;
        @(negedge clk); #1;
        if (mid_action == 1) rst_i = 1'b1;
        if (mid_action == 2) begin
            rstn = 1'b0;
            #1;
            checkOutput("rstn_mid_outputs",
                        {fb_we_o, fb_addr_o, fb_data_o, disp_on_o, start_line_o, frame_done_o, db_o, db_oe_o}, 64'd0);
            @(negedge clk); #1;
            rstn = 1'b1;
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    {fb_we_o, fb_addr_o, fb_data_o, disp_on_o, start_line_o, frame_done_o, db_o, db_oe_o}, 64'd0);
        rstn = 1'b1;

        // Column 0, page 2, one data byte on chip 0.
        clearLogs();
        applyStimulus(1'b0, 1'b0, 2'b01, 8'h40, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 8'hBA, 0);
        applyStimulus(1'b1, 1'b0, 2'b01, 8'hA5, 0);
        checkOutput("drv_seq_count", wr_log.size(), 1);
        if (wr_log.size() > 0) checkOutput("drv_seq_write", wr_log[0], {10'h080, 8'hA5});
        checkOutput("drv_seq_model_col0", m_col[0], 1);

        // Chip 1 column wrap from 63 to 0 on page 7.
        clearLogs();
        applyStimulus(1'b0, 1'b0, 2'b10, 8'h7F, 0);
        applyStimulus(1'b0, 1'b0, 2'b10, 8'hBF, 0);
        applyStimulus(1'b1, 1'b0, 2'b10, 8'h11, 0);
        applyStimulus(1'b1, 1'b0, 2'b10, 8'h22, 0);
        checkOutput("wrap_count", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            checkOutput("wrap_first", wr_log[0], {10'h3FF, 8'h11});
            checkOutput("wrap_second", wr_log[1], {10'h3C0, 8'h22});
        end
        checkOutput("wrap_model_col1", m_col[1], 1);

        // Both chips selected: two back-to-back writes.
        applyStimulus(1'b0, 1'b0, 2'b11, 8'h40, 0);
        applyStimulus(1'b0, 1'b0, 2'b11, 8'hB8, 0);
        clearLogs();
        applyStimulus(1'b1, 1'b0, 2'b11, 8'h3C, 0);
        checkOutput("both_count", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            checkOutput("both_chip0", wr_log[0], {10'h000, 8'h3C});
            checkOutput("both_chip1", wr_log[1], {10'h200, 8'h3C});
            checkOutput("both_consecutive", wr_cyc[1] - wr_cyc[0], 1);
        end

        // Display on, status reads, start line, ignored codes and deselected transfers.
        clearLogs();
        applyStimulus(1'b0, 1'b0, 2'b01, 8'h3F, 0);
        checkOutput("disp_on", disp_on_o, 2'b01);
        checkOutput("frame_done_pulses", fd_count, 1);
        applyStimulus(1'b0, 1'b1, 2'b01, 8'h00, 0);
        applyStimulus(1'b0, 1'b1, 2'b10, 8'h00, 0);
        applyStimulus(1'b0, 1'b1, 2'b11, 8'h00, 0);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, 0);
        checkOutput("status_count", rd_log.size(), 4);
        if (rd_log.size() > 3) begin
            checkOutput("status_chip0_on", rd_log[0], 8'h00);
            checkOutput("status_chip1_off", rd_log[1], 8'h20);
            checkOutput("status_lowest_chip", rd_log[2], 8'h00);
            checkOutput("data_read_zero", rd_log[3], 8'h00);
        end
        applyStimulus(1'b0, 1'b0, 2'b10, 8'hC5, 0);
        checkOutput("start_line", start_line_o, 12'h140);
        clearLogs();
        applyStimulus(1'b0, 1'b0, 2'b11, 8'h00, 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h99, 0);
        checkOutput("ignored_writes", wr_log.size(), 0);
        checkOutput("ignored_state", {disp_on_o, start_line_o}, {2'b01, 12'h140});

        // Panel reset held: writes ignored, status reports reset.
        @(negedge clk); #1;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        clearLogs();
        applyStimulus(1'b1, 1'b0, 2'b01, 8'h77, 0);
        applyStimulus(1'b0, 1'b0, 2'b01, 8'h3F, 0);
        applyStimulus(1'b0, 1'b1, 2'b01, 8'h00, 0);
        checkOutput("rst_no_write", wr_log.size(), 0);
        checkOutput("rst_no_frame_done", fd_count, 0);
        if (rd_log.size() > 0) checkOutput("rst_status", rd_log[0], 8'h30);
        else checkOutput("rst_status_count", rd_log.size(), 1);
        checkOutput("rst_state", {disp_on_o, start_line_o}, 14'd0);
        @(negedge clk); #1;
        rst_i = 1'b0;

        // Panel reset rising between the two halves of a both-chip write.
        clearLogs();
        applyStimulus(1'b1, 1'b0, 2'b11, 8'h5A, 1);
        checkOutput("rst_cancel_count", wr_log.size(), 1);
        if (wr_log.size() > 0) checkOutput("rst_cancel_chip0", wr_log[0], {10'h000, 8'h5A});
        rst_i = 1'b0;

        // Async reset between the two halves, then a normal command.
        clearLogs();
        applyStimulus(1'b1, 1'b0, 2'b11, 8'hC3, 2);
        checkOutput("rstn_cancel_count", wr_log.size(), 1);
        checkOutput("rstn_after_outputs",
                    {fb_we_o, fb_addr_o, fb_data_o, disp_on_o, start_line_o, frame_done_o, db_o, db_oe_o}, 64'd0);
        clearLogs();
        applyStimulus(1'b0, 1'b0, 2'b01, 8'h3F, 0);
        checkOutput("post_rstn_disp_on", disp_on_o, 2'b01);
        checkOutput("post_rstn_frame_done", fd_count, 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
